// File: rtl/pipe_delay_pkg.sv
// Shared definitions for the elastic delay line (package delay_pkg).
//   MAX_DEPTH  : largest supported number of register stages
//   occ_width  : width of the occupancy count for a given depth (never below 1 bit)
// The per-instance beat type is declared inside each module as
// logic [WIDTH*LANES-1:0], since a package cannot take parameters.
package delay_pkg;

    localparam int MAX_DEPTH = 32;

    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_delay_stage.sv
// pipe_stage: one {valid, data} register of the elastic delay line.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of the valid bit (data is kept)
//   vld_in, dat_in  beat offered by the upstream stage
//   ready_in        downstream stage (or sink) can take this stage's beat
//   ready_out       this stage can load a new beat this cycle
//   vld_out, dat_out  registered beat
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         vld_in,
    input  logic [W-1:0] dat_in,
    input  logic         ready_in,
    output logic         ready_out,
    output logic         vld_out,
    output logic [W-1:0] dat_out
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    always_comb begin
        // An empty stage fills even when downstream is stalled: this is
        // what collapses bubbles.
        ready_out = !vld_q || ready_in;
        vld_d     = vld_q;
        dat_d     = dat_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (ready_out) begin
            vld_d = vld_in;
            if (vld_in) begin
                dat_d = dat_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_out = vld_q;
    assign dat_out = dat_q;

endmodule

// File: rtl/pipe_delay.sv
// pipe_delay: elastic valid/ready delay line of DEPTH stages, WIDTH*LANES bits wide.
// Unstalled latency is DEPTH cycles at one beat per cycle; DEPTH=0 is a wire.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop every held beat and the beat offered this cycle
//   in_data/in_valid/in_ready     upstream handshake
//   out_data/out_valid/out_ready  downstream handshake
//   occupancy             beats held; present only when PIPE_DELAY_OCC_EN is defined
module pipe_delay
    import delay_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [WIDTH*LANES-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH*LANES-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef PIPE_DELAY_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    localparam int DW = WIDTH * LANES;

    if (DEPTH == 0) begin : g_bypass
        assign out_data  = in_data;
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
`ifdef PIPE_DELAY_OCC_EN
        assign occupancy = '0;
`endif
    end else begin : g_pipe
        // Index k is the input of stage k; index DEPTH is the pipe output.
        logic          vld [DEPTH+1];
        logic [DW-1:0] dat [DEPTH+1];
        logic          rdy [DEPTH+1];

        assign vld[0]     = in_valid;
        assign dat[0]     = in_data;
        assign rdy[DEPTH] = out_ready;

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            pipe_stage #(.W(DW)) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (flush),
                .vld_in    (vld[k]),
                .dat_in    (dat[k]),
                .ready_in  (rdy[k+1]),
                .ready_out (rdy[k]),
                .vld_out   (vld[k+1]),
                .dat_out   (dat[k+1])
            );
        end

        assign out_valid = vld[DEPTH];
        assign out_data  = dat[DEPTH];
        // During flush the offered beat is swallowed, so upstream sees it taken.
        assign in_ready  = flush || rdy[0];

`ifdef PIPE_DELAY_OCC_EN
        localparam int OW = occ_width(DEPTH);
        logic [OW-1:0] occ_q, occ_d;
        logic          acc, emit;

        always_comb begin
            acc   = in_valid && in_ready && !flush;
            emit  = out_valid && out_ready;
            occ_d = occ_q;
            if (flush) begin
                occ_d = '0;
            end else if (acc && !emit) begin
                occ_d = occ_q + OW'(1);
            end else if (!acc && emit) begin
                occ_d = occ_q - OW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign occupancy = occ_q;
`endif
    end

endmodule

// File: tb/tb_pipe_delay.sv
module tb_pipe_delay;
    import delay_pkg::*;

    function automatic int dep_of(input int i);
        case (i)
            0:       return 3;
            1:       return 4;
            2:       return 1;
            default: return 5;
        endcase
    endfunction

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] in_data   [4];
    logic       in_valid  [4];
    logic       out_ready [4];
    logic       flush     [4];
    logic [7:0] out_data  [4];
    logic       out_valid [4];
    logic       in_ready  [4];
    logic [5:0] occ       [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
`ifdef PIPE_DELAY_OCC_EN
        logic [occ_width(dep_of(g))-1:0] occ_w;
        assign occ[g] = 6'(occ_w);
`else
        assign occ[g] = '0;
`endif
        pipe_delay #(.WIDTH(8), .LANES(1), .DEPTH(dep_of(g))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush[g]),
            .in_data   (in_data[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .out_data  (out_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g])
`ifdef PIPE_DELAY_OCC_EN
            ,
            .occupancy (occ_w)
`endif
        );
    end

    // DEPTH=0, 4 lanes of 8 bits
    logic [31:0] z_in_data, z_out_data;
    logic        z_in_valid, z_out_valid, z_in_ready, z_out_ready, z_flush;
`ifdef PIPE_DELAY_OCC_EN
    logic [occ_width(0)-1:0] z_occ;
`endif

    pipe_delay #(.WIDTH(8), .LANES(4), .DEPTH(0)) u_zero (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (z_flush),
        .in_data   (z_in_data),
        .in_valid  (z_in_valid),
        .in_ready  (z_in_ready),
        .out_data  (z_out_data),
        .out_valid (z_out_valid),
        .out_ready (z_out_ready)
`ifdef PIPE_DELAY_OCC_EN
        ,
        .occupancy (z_occ)
`endif
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: beats in arrival order, each with its stage position
    // (0 = input side, depth-1 = output). Beats slide toward the output
    // whenever the slot ahead is free or is being vacated.
    typedef struct {
        logic [7:0] d;
        int         pos;
    } beat_t;
    beat_t mq[$];

    int n_in, n_out, first_out, cyc;

    task automatic cycle(input int i);
        int dep;
        int lim;
        bit exp_ov, exp_ir, emit, acc;
        dep = dep_of(i);
        #1;
        exp_ov = (mq.size() > 0) && (mq[0].pos == dep - 1);
        exp_ir = flush[i] || (mq.size() < dep) || out_ready[i];
        chk("out_valid", out_valid[i], exp_ov);
        chk("in_ready", in_ready[i], exp_ir);
        if (exp_ov) chk("out_data", out_data[i], mq[0].d);
`ifdef PIPE_DELAY_OCC_EN
        chk("occupancy", occ[i], mq.size());
`endif
        if (out_valid[i] && out_ready[i]) n_out++;
        if (in_valid[i] && in_ready[i] && !flush[i]) n_in++;
        if (out_valid[i] && first_out < 0) first_out = cyc;
        emit = exp_ov && out_ready[i];
        acc  = in_valid[i] && exp_ir;
        if (flush[i]) begin
            mq.delete();
        end else begin
            if (emit) void'(mq.pop_front());
            lim = dep;
            foreach (mq[k]) begin
                if (mq[k].pos + 1 < lim) mq[k].pos++;
                lim = mq[k].pos;
            end
            if (acc) mq.push_back('{d: in_data[i], pos: 0});
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int j = 0; j < 4; j++) begin
            in_data[j]   = '0;
            in_valid[j]  = 1'b0;
            out_ready[j] = 1'b0;
            flush[j]     = 1'b0;
        end
        z_in_data   = '0;
        z_in_valid  = 1'b0;
        z_out_ready = 1'b0;
        z_flush     = 1'b0;
    endtask

    task automatic start(input int i);
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b0;
        flush[i]     = 1'b0;
        n_in = 0; n_out = 0; first_out = -1; cyc = 0;
    endtask

    initial begin
        logic [7:0] nxt;
        rst_n = 1'b0;
        idle_all();
        mq.delete();

        // Reset state
        #3;
        for (int j = 0; j < 4; j++) begin
            chk("rst_out_valid", out_valid[j], 1'b0);
            chk("rst_out_data", out_data[j], 8'h00);
            chk("rst_in_ready", in_ready[j], 1'b1);
`ifdef PIPE_DELAY_OCC_EN
            chk("rst_occ", occ[j], 0);
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 1: DEPTH=3 back-to-back 0x01..0x0A, sink always ready
        start(0);
        out_ready[0] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid[0] = (c < 10);
            in_data[0]  = 8'(c + 1);
            cycle(0);
        end
        chk("t1_first_out_cycle", first_out, 3);
        chk("t1_beats_out", n_out, 10);

        // 2: DEPTH=3 stalled sink, continuous offer, then drain
        start(0);
        nxt = 8'h20;
        in_valid[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_data[0] = nxt;
            #1;
            if (in_ready[0]) nxt++;
            #0 cycle(0);
        end
        chk("t2_accepts_stalled", n_in, 3);
        chk("t2_frozen_data", out_data[0], 8'h20);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        for (int c = 0; c < 6; c++) cycle(0);
        chk("t2_drained", n_out, 3);

        // 3: DEPTH=4 bubble collapse behind a stalled 0x55
        start(1);
        in_valid[1] = 1'b1;
        in_data[1]  = 8'h55;
        cycle(1);
        in_valid[1] = 1'b0;
        for (int c = 0; c < 10; c++) cycle(1);
        chk("t3_held_data", out_data[1], 8'h55);
        in_valid[1] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data[1] = 8'(8'h56 + c);
            cycle(1);
        end
        chk("t3_accepts", n_in, 4);
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        for (int c = 0; c < 8; c++) cycle(1);
        chk("t3_drained", n_out, 4);

        // 4: flush with two beats in flight and one offered in the same cycle
        start(0);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h11; cycle(0);
        in_data[0]  = 8'h12; cycle(0);
        in_data[0]  = 8'hEE;
        flush[0]    = 1'b1;
        cycle(0);
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        for (int c = 0; c < 6; c++) cycle(0);
        chk("t4_nothing_out", n_out, 0);

        // 5: asynchronous reset between clock edges
        start(0);
        in_valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_data[0] = 8'(8'hA0 + c);
            cycle(0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_out_valid", out_valid[0], 1'b0);
        chk("t5_async_out_data", out_data[0], 8'h00);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start(0);
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = 8'h3C;
        cycle(0);
        in_valid[0]  = 1'b0;
        for (int c = 0; c < 5; c++) cycle(0);
        chk("t5_first_out_cycle", first_out, 3);

        // 6a: DEPTH=0, 4 lanes, pure combinational pass-through
        for (int c = 0; c < 8; c++) begin
            z_in_data   = $urandom;
            z_in_valid  = 1'($urandom);
            z_out_ready = 1'($urandom);
            z_flush     = 1'($urandom);
            #1;
            chk("d0_out_data", z_out_data, z_in_data);
            chk("d0_out_valid", z_out_valid, z_in_valid);
            chk("d0_in_ready", z_in_ready, z_out_ready);
`ifdef PIPE_DELAY_OCC_EN
            chk("d0_occ", z_occ, 0);
`endif
            @(negedge clk);
        end

        // 6b: random valid/ready/flush scoreboard for DEPTH=1 and DEPTH=5
        for (int i = 2; i < 4; i++) begin
            start(i);
            for (int c = 0; c < 300; c++) begin
                in_data[i]   = 8'($urandom);
                in_valid[i]  = ($urandom_range(0, 3) != 0);
                out_ready[i] = ($urandom_range(0, 2) != 0);
                flush[i]     = ($urandom_range(0, 31) == 0);
                cycle(i);
            end
            in_valid[i]  = 1'b0;
            flush[i]     = 1'b0;
            out_ready[i] = 1'b1;
            for (int c = 0; c < 8; c++) cycle(i);
            chk("rand_drained_valid", out_valid[i], 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
